// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response channel between fetch and imem.
interface fetch_unit_if;
    logic        IMEM_Req_Valid;
    logic        IMEM_Req_Ready;
    logic [31:0] IMEM_Req_Addr;
    logic        IMEM_Resp_Valid;
    logic [31:0] IMEM_Resp_Data;
    modport master (
        output IMEM_Req_Valid, IMEM_Req_Addr,
        input  IMEM_Req_Ready, IMEM_Resp_Valid, IMEM_Resp_Data
    );
    modport slave (
        input  IMEM_Req_Valid, IMEM_Req_Addr,
        output IMEM_Req_Ready, IMEM_Resp_Valid, IMEM_Resp_Data
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end pairing in-order imem responses with their PCs, flushed on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master imem,
    input  logic         Redirect_En,
    input  logic [31:0]  Redirect_PC,
    input  logic         Stall,
    output logic [31:0]  Instr,
    output logic [31:0]  Instr_PC,
    output logic         Instr_Valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr, discard, flush_discard;
    logic [PW:0]   occupancy;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic          accept, fill, pop;
    assign occupancy          = {1'b0, alloc_ptr - rd_ptr} + {1'b0, discard};
    assign imem.IMEM_Req_Valid = !RST && occupancy < (PW+1)'(DEPTH);
    assign imem.IMEM_Req_Addr  = fetch_pc;
    assign accept             = imem.IMEM_Req_Valid && imem.IMEM_Req_Ready;
    assign fill               = imem.IMEM_Resp_Valid && discard == '0;
    assign Instr_Valid        = fill_ptr != rd_ptr;
    assign pop                = Instr_Valid && !Stall;
    assign Instr              = Instr_Valid ? data_q[rd_ptr[AW-1:0]] : 32'h0000_0013;
    assign Instr_PC           = Instr_Valid ? pc_q[rd_ptr[AW-1:0]] : '0;
    // on a flush every response still owed by memory is stale
    assign flush_discard = discard + (alloc_ptr - fill_ptr) + PW'(accept) - PW'(imem.IMEM_Resp_Valid);
    always_ff @(posedge CLK) begin
        if (RST) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            discard   <= '0;
            fetch_pc  <= {RESET_PC[31:2], 2'b00};
        end else if (Redirect_En) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            discard   <= flush_discard;
            fetch_pc  <= {Redirect_PC[31:2], 2'b00};
        end else begin
            if (accept) begin
                alloc_ptr <= alloc_ptr + 1'b1;
                fetch_pc  <= fetch_pc + 32'd4;
            end
            if (fill) fill_ptr <= fill_ptr + 1'b1;
            else if (imem.IMEM_Resp_Valid) discard <= discard - 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge CLK) begin
        if (accept) pc_q[alloc_ptr[AW-1:0]] <= fetch_pc;
        if (fill) data_q[fill_ptr[AW-1:0]] <= imem.IMEM_Resp_Data;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fixed-latency imem model plus a queue-level reference of the fetch stream.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h8000_0000;
    logic        CLK = 0, RST = 1, Redirect_En = 0, Stall = 0, Instr_Valid;
    logic [31:0] Redirect_PC = 0, Instr, Instr_PC;
    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .imem(bus), .Redirect_En(Redirect_En), .Redirect_PC(Redirect_PC),
        .Stall(Stall), .Instr(Instr), .Instr_PC(Instr_PC), .Instr_Valid(Instr_Valid)
    );
    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit filled; } ent_t;
    typedef struct { bit stl; bit iv; logic [31:0] pc; bit rv; } row_t;
    typedef struct { logic [31:0] rpc; logic [31:0] exp; } rdr_t;

    mreq_t       mq[$];
    ent_t        q[$];
    int          disc = 0, cyc = 0, L = 1, passed = 0, total = 0;
    logic [31:0] mpc = RPC;
    logic        s_iv, s_rv;
    logic [31:0] s_pc, s_instr, s_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        else passed++;
    endtask

    task automatic cycle(input bit rdy, input bit stl, input bit redir, input logic [31:0] rpc);
        logic rv;
        bit ev, acc;
        bus.IMEM_Req_Ready = rdy;
        Stall = stl;
        Redirect_En = redir;
        Redirect_PC = rpc;
        rv = !RST && mq.size() > 0 && mq[0].due == cyc;
        bus.IMEM_Resp_Valid = rv;
        bus.IMEM_Resp_Data = rv ? memf(mq[0].addr) : 32'($urandom);
        #1;
        s_iv = Instr_Valid; s_rv = bus.IMEM_Req_Valid; s_pc = Instr_PC; s_instr = Instr; s_addr = bus.IMEM_Req_Addr;
        ev = q.size() > 0 && q[0].filled;
        chk("req_valid", 32'(s_rv), 32'(!RST && (q.size() + disc < 4)));
        chk("req_addr", s_addr, mpc);
        chk("instr_valid", 32'(s_iv), 32'(ev));
        chk("instr", s_instr, ev ? memf(q[0].pc) : 32'h13);
        chk("instr_pc", s_pc, ev ? q[0].pc : 32'h0);
        acc = s_rv && rdy;
        if (RST) begin
            mq.delete(); q.delete(); disc = 0; mpc = RPC;
        end else begin
            if (acc) mq.push_back('{s_addr, cyc + L});
            if (rv) void'(mq.pop_front());
            if (redir) begin
                q.delete(); disc = mq.size(); mpc = {rpc[31:2], 2'b00};
            end else begin
                if (rv) begin
                    if (disc > 0) disc--;
                    else for (int i = 0; i < q.size(); i++) if (!q[i].filled) begin q[i].filled = 1; break; end
                end
                if (ev && !stl) void'(q.pop_front());
                if (acc) begin q.push_back('{mpc, 1'b0}); mpc += 4; end
            end
        end
        @(posedge CLK); #2;
        cyc++;
    endtask

    initial begin
        row_t        tab[18];
        rdr_t        rt[4];
        logic [31:0] addr0, got[$];
        int          n;
        tab = '{'{0,0,32'h0,1}, '{0,0,32'h0,1}, '{0,1,RPC,1}, '{0,1,RPC+4,1}, '{0,1,RPC+8,1},
                '{1,1,RPC+12,1}, '{1,1,RPC+12,1}, '{1,1,RPC+12,0}, '{1,1,RPC+12,0}, '{1,1,RPC+12,0},
                '{1,1,RPC+12,0}, '{0,1,RPC+12,0}, '{0,1,RPC+16,1}, '{0,1,RPC+20,1}, '{0,1,RPC+24,1},
                '{0,1,RPC+28,1}, '{0,1,RPC+32,1}, '{0,1,RPC+36,1}};
        rt = '{'{32'h0000_0102, 32'h0000_0100}, '{32'h0000_0003, 32'h0000_0000},
               '{32'hFFFF_FFFE, 32'hFFFF_FFFC}, '{32'h1234_5679, 32'h1234_5678}};
        bus.IMEM_Req_Ready = 0; bus.IMEM_Resp_Valid = 0; bus.IMEM_Resp_Data = 0;
        @(posedge CLK); #2;
        cycle(1, 0, 0, 0);
        RST = 0;
        // startup at L=1 then a 6-cycle stall
        for (int i = 0; i < 18; i++) begin
            cycle(1, tab[i].stl, 0, 0);
            chk("tab_iv", 32'(s_iv), 32'(tab[i].iv));
            chk("tab_pc", s_pc, tab[i].pc);
            chk("tab_rv", 32'(s_rv), 32'(tab[i].rv));
            if (tab[i].iv) chk("tab_instr", s_instr, memf(tab[i].pc));
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 1, rt[k].rpc);
            cycle(1, 0, 0, 0);
            n = 1;
            chk("redir_addr", s_addr, rt[k].exp);
            chk("redir_iv_drop", 32'(s_iv), 0);
            while (!s_iv && n < 20) begin cycle(1, 0, 0, 0); n++; end
            chk("redir_pc", s_pc, rt[k].exp);
            chk("redir_instr", s_instr, memf(rt[k].exp));
            chk("redir_lat", n, 3);
            repeat (3) cycle(1, 0, 0, 0);
        end
        cycle(0, 0, 0, 0);
        addr0 = s_addr;
        chk("rdy_low_valid", 32'(s_rv), 1);
        repeat (3) begin
            cycle(0, 0, 0, 0);
            chk("rdy_low_addr", s_addr, addr0);
            chk("rdy_low_valid", 32'(s_rv), 1);
        end
        repeat (6) cycle(1, 0, 0, 0);
        L = 3;
        for (int i = 0; i < 20 && mq.size() < 3; i++) cycle(1, 0, 0, 0);
        chk("l3_inflight", mq.size(), 3);
        cycle(1, 0, 1, 32'h100);
        for (int i = 0; i < 20 && got.size() < 2; i++) begin
            cycle(1, 0, 0, 0);
            if (s_iv) got.push_back(s_pc);
        end
        chk("l3_first", got.size() > 0 ? got[0] : 32'hFFFF_FFFF, 32'h100);
        chk("l3_second", got.size() > 1 ? got[1] : 32'hFFFF_FFFF, 32'h104);
        for (int i = 0; i < 20 && !(mq.size() >= 2 && q.size() > 0 && q[0].filled); i++) cycle(1, 1, 0, 0);
        RST = 1;
        cycle(1, 1, 0, 0);
        RST = 0;
        cycle(1, 0, 0, 0);
        chk("rst_iv", 32'(s_iv), 0);
        chk("rst_addr", s_addr, RPC);
        chk("rst_rv", 32'(s_rv), 1);
        n = 0;
        while (!s_iv && n < 20) begin cycle(1, 0, 0, 0); n++; end
        chk("rst_first_pc", s_pc, RPC);
        for (int p = 0; p < 3; p++) begin
            RST = 1;
            cycle(1, 0, 0, 0);
            RST = 0;
            L = 1 + int'($urandom % 4);
            repeat (400) cycle($urandom % 4 != 0, $urandom % 4 == 0, $urandom % 16 == 0, $urandom);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
